// File: rtl/oam_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : oam_ctrl
// Brief    : Primary OAM port owner. Arbitrates the single OAM RAM port
//            between sprite evaluation, the $4014 DMA engine and CPU
//            $2003/$2004 accesses, holds OAMADDR and sequences OAM DMA.
// Revision : 1.0 - initial release
// ============================================================================
module oam_ctrl #(
  parameter int DMA_LEN    = 256,
  parameter int RENDER_INC = 4
) (
  input  logic        clk,
  input  logic        rst,
  // CPU register interface
  input  logic        oamaddr_we,
  input  logic        oamdata_we,
  input  logic        oamdata_re,
  input  logic [7:0]  cpu_data_i,
  output logic [7:0]  cpu_data_o,
  // DMA request and CPU bus
  input  logic        dma_start,
  input  logic [7:0]  dma_page,
  input  logic        cpu_odd,
  output logic        dma_halt,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  input  logic [7:0]  bus_data_i,
  // Rendering status and sprite evaluation
  input  logic        rendering,
  input  logic        sprite_fetch,
  input  logic        eval_req,
  input  logic [7:0]  eval_addr,
  output logic [7:0]  eval_data_o,
  // OAM RAM port
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  oam_din,
  input  logic [7:0]  oam_dout
);

  // DMA sequencer states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } dma_state_e;

  localparam logic [8:0] LAST_COUNT = 9'(DMA_LEN);
  localparam logic [7:0] INC_STEP   = 8'(RENDER_INC);

  dma_state_e  state_q, state_d;
  logic [7:0]  page_q,  page_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  oamaddr_q, oamaddr_d;

  // DMA data capture across eval stalls
  logic        stall_q, stall_d;
  logic [7:0]  hold_q,  hold_d;

  // $2004 read return path
  logic        rd_pend_q, rd_pend_d;
  logic        rd_attr_q, rd_attr_d;
  logic [7:0]  rdata_q,   rdata_d;

  logic        dma_commit;
  logic [7:0]  dma_din;
  logic        cpu_grant;
  logic        cpu_wr;
  logic        cpu_rd;
  logic        render_bump;
  logic [7:0]  rd_fmt;

  // DMA state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      count_q <= 9'd0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      count_q <= count_d;
    end
  end

  // DMA next-state and bus-side outputs
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    count_d    = count_q;
    dma_commit = 1'b0;
    dma_halt   = (state_q != S_IDLE);
    bus_rd     = (state_q == S_READ);
    bus_addr   = {page_q, count_q[7:0]};
    case (state_q)
      S_IDLE: begin
        if (dma_start) begin
          page_d  = dma_page;
          count_d = 9'd0;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // An odd start needs one extra cycle so reads land on get-cycles
        state_d = cpu_odd ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Evaluation owns the port this cycle: hold the byte, retry next
        if (!eval_req) begin
          dma_commit = 1'b1;
          count_d    = count_q + 9'd1;
          state_d    = (count_q + 9'd1 == LAST_COUNT) ? S_IDLE : S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port arbitration, OAMADDR update and read formatting
  always_comb begin
    // Bus data is only valid the first WRITE cycle; after a stall use the copy
    dma_din     = stall_q ? hold_q : bus_data_i;
    stall_d     = (state_q == S_WRITE) && eval_req;
    hold_d      = dma_din;

    // CPU data port accesses only while no DMA is running and eval is quiet
    cpu_grant   = (state_q == S_IDLE) && !eval_req;
    cpu_wr      = oamdata_we && !rendering && cpu_grant;
    cpu_rd      = oamdata_re && cpu_grant;
    // The rendering-time OAMDATA bump does not touch the RAM port
    render_bump = oamdata_we && rendering && (state_q == S_IDLE);

    oamaddr_d = oamaddr_q;
    if (dma_commit) begin
      oamaddr_d = oamaddr_q + 8'd1;
    end else if (oamaddr_we) begin
      oamaddr_d = cpu_data_i;
    end else if (cpu_wr) begin
      oamaddr_d = oamaddr_q + 8'd1;
    end else if (render_bump) begin
      oamaddr_d = oamaddr_q + INC_STEP;
    end
    // Sprite tile fetches clear OAMADDR continuously
    if (rendering && sprite_fetch) begin
      oamaddr_d = 8'h00;
    end

    oam_addr = eval_req ? eval_addr : oamaddr_q;
    // Gating with rst keeps an in-flight write from landing during reset
    oam_we   = !rst && (dma_commit || cpu_wr);
    oam_din  = dma_commit ? dma_din : cpu_data_i;

    eval_data_o = oam_dout;

    // Attribute bytes have no storage in bits 4:2
    rd_pend_d = cpu_rd;
    rd_attr_d = cpu_rd ? (oamaddr_q[1:0] == 2'd2) : rd_attr_q;
    rd_fmt    = rd_attr_q ? (oam_dout & 8'hE3) : oam_dout;
    rdata_d   = rd_pend_q ? rd_fmt : rdata_q;
    cpu_data_o = rd_pend_q ? rd_fmt : rdata_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      oamaddr_q <= 8'h00;
      stall_q   <= 1'b0;
      hold_q    <= 8'h00;
      rd_pend_q <= 1'b0;
      rd_attr_q <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      oamaddr_q <= oamaddr_d;
      stall_q   <= stall_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
      rd_attr_q <= rd_attr_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/oam_ctrl.md
Name: oam_ctrl

Overview:
Owns the single port of the 256-byte primary OAM and shares it between three requesters: sprite evaluation, OAM DMA ($4014) and CPU OAMADDR/OAMDATA ($2003/$2004) accesses. It holds the OAMADDR register and runs the 513/514-cycle DMA sequencer that pulls a CPU page into OAM. It sits between the CPU register decode, the CPU bus and the sprite evaluation engine.

Parameters:
- DMA_LEN, 256, number of bytes transferred per DMA.
- RENDER_INC, 4, OAMADDR increment applied on an OAMDATA write that is ignored during rendering.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- oamaddr_we  in  1  CPU write to $2003
- oamdata_we  in  1  CPU write to $2004
- oamdata_re  in  1  CPU read of $2004
- cpu_data_i  in  8  CPU write data
- cpu_data_o  out  8  $2004 read data
- dma_start  in  1  one-cycle pulse on a $4014 write
- dma_page  in  8  page sampled with dma_start
- cpu_odd  in  1  current CPU cycle is odd
- dma_halt  out  1  stalls the CPU while a DMA is active
- bus_addr  out  16  DMA source address
- bus_rd  out  1  DMA bus read strobe
- bus_data_i  in  8  bus read data, valid the cycle after bus_rd
- rendering  in  1  rendering enabled on a visible or pre-render line
- sprite_fetch  in  1  sprite-fetch window (dots 257-320)
- eval_req  in  1  evaluation engine requests OAM
- eval_addr  in  8  evaluation address
- eval_data_o  out  8  OAM data to evaluation
- oam_addr  out  8  OAM RAM address
- oam_we  out  1  OAM RAM write enable
- oam_din  out  8  OAM RAM write data
- oam_dout  in  8  OAM RAM read data, 1-cycle synchronous latency

Behaviour:
- Reset values: oamaddr=0, DMA state IDLE, dma_halt=0, bus_rd=0, bus_addr=0, oam_we=0, cpu_data_o=0, byte counter=0.
- Port priority each cycle: eval_req, then the DMA write, then the CPU. oam_addr takes the winner's address. With no requester, oam_addr=oamaddr.
- A CPU access that loses arbitration is lost, not queued. A DMA write that collides with eval_req stalls in WRITE with no counter advance.
- oamaddr_we: oamaddr<=cpu_data_i.
- oamdata_we with rendering=0: write cpu_data_i at oamaddr, then oamaddr+1 (8-bit wrap 255->0).
- oamdata_we with rendering=1: no write; oamaddr+=RENDER_INC (wraps).
- sprite_fetch=1 and rendering=1: oamaddr<=0 every cycle; this overrides CPU updates.
- oamdata_re: cpu_data_o is valid the cycle after the strobe. It is oam_dout of the address presented with the strobe, and oamaddr does not change. If that address[1:0]==2, bits 4:2 read 0.
- eval_data_o=oam_dout; the evaluation engine accounts for the 1-cycle latency.
- DMA FSM:
  - IDLE: on dma_start, latch the page, count=0, go to HALT. dma_start while not IDLE is ignored.
  - HALT: 1 cycle, dma_halt=1. If cpu_odd=1, go to ALIGN; else go to READ.
  - ALIGN: 1 cycle, then READ.
  - READ: bus_addr={page,count}, bus_rd=1, then WRITE.
  - WRITE: oam_din=bus_data_i, oam_we=1 at oamaddr, oamaddr+1, count+1. Go to READ, or to IDLE once count reaches DMA_LEN.
- Total length: 513 cycles for an even start, 514 for an odd start (absent eval stalls).
- dma_halt=1 in every non-IDLE state and deasserts on the cycle IDLE is re-entered.
- A DMA starting at oamaddr=k wraps modulo 256, so the page lands rotated by k.
- CPU oamdata_we/re during DMA are dropped; the CPU is halted, so this is defensive only.
- rst mid-DMA: return to IDLE next cycle and drop dma_halt. A write in flight is not committed.

Test Plan:
- Reset, oamaddr_we=0x10, then oamdata_we 0xAB, 0xCD (rendering=0) -> OAM[0x10]=0xAB, OAM[0x11]=0xCD, oamaddr=0x12.
- oamaddr=0xFE, DMA page 0x02 with bus data = low address byte, cpu_odd=0 -> dma_halt high exactly 513 cycles; OAM[(0xFE+i)&0xFF]=i for all i; final oamaddr=0xFE.
- Same DMA with cpu_odd=1 -> dma_halt high 514 cycles; first bus_rd exactly one cycle later than in the even case.
- rendering=1, oamaddr=0x20, oamdata_we 0x55 -> no oam_we, oamaddr=0x24. Then sprite_fetch=1 -> oamaddr=0.
- OAM[0x06]=0xFF, oamaddr=0x06, oamdata_re -> cpu_data_o=0xE3 next cycle. Same read at address 0x07 -> 0xFF.
- DMA WRITE colliding with eval_req for 3 cycles -> oam_addr=eval_addr during the collision, DMA stretched by 3 cycles, no bytes lost. rst at DMA byte 100 -> dma_halt=0 next cycle, OAM[100+] unchanged.
